// File: rtl/softreg_cfg_pkg.sv
// softreg_cfg_pkg
// Shared definitions for the PageRank softreg responder: the run-control
// state enum, softreg register addresses, STATUS bit positions and a helper
// that assembles the STATUS read word.
package softreg_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Softreg register map (byte-free word addresses as seen on softreg_req_addr)
  localparam logic [31:0] ADDR_N_VERT           = 32'h0000_0000;
  localparam logic [31:0] ADDR_N_INEDGES        = 32'h0000_0001;
  localparam logic [31:0] ADDR_VADDR            = 32'h0000_0002;
  localparam logic [31:0] ADDR_IEADDR           = 32'h0000_0003;
  localparam logic [31:0] ADDR_WRITE_ADDR0      = 32'h0000_0004;
  localparam logic [31:0] ADDR_WRITE_ADDR1      = 32'h0000_0005;
  localparam logic [31:0] ADDR_DONE_READ_PARAMS = 32'h0000_0006;
  localparam logic [31:0] ADDR_DONE_ALL         = 32'h0000_0007;
  localparam logic [31:0] ADDR_STATUS           = 32'h0000_0008;

  localparam int STATUS_BUSY_BIT     = 0;
  localparam int STATUS_DONE_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;

  function automatic logic [63:0] status_word(input logic busy,
                                              input logic done,
                                              input logic overflow);
    logic [63:0] w;
    w = '0;
    w[STATUS_BUSY_BIT]     = busy;
    w[STATUS_DONE_BIT]     = done;
    w[STATUS_OVERFLOW_BIT] = overflow;
    return w;
  endfunction

endpackage

// File: rtl/softreg_cfg.sv
// softreg_cfg
// Softreg responder for the PageRank core. Decodes host softreg requests,
// holds the run parameters, pulses core_start when the host signals that the
// parameters are ready, latches the core's final sum, and answers host reads.
// A DONE_ALL read issued before the core finishes is parked until completion
// so the host can block on a single read.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   softreg_req_valid/isWrite/    host request (one cycle, no backpressure)
//     addr/data
//   softreg_resp_valid/data       registered one-cycle read response
//   n_vert .. write_addr1         parameter registers (64 bit each)
//   core_start                    one-cycle start pulse to the core
//   core_busy                     high while the core runs
//   core_done, core_result        completion pulse and final sum from core
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | after reset; parameters writable, waiting for DONE_READ_PARAMS
// RUN   | core running; parameters frozen, core_busy high
// DONE  | core finished; result held, parameters writable, restart allowed
module softreg_cfg
  import softreg_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        softreg_req_valid,
  input  logic        softreg_req_isWrite,
  input  logic [31:0] softreg_req_addr,
  input  logic [63:0] softreg_req_data,

  output logic        softreg_resp_valid,
  output logic [63:0] softreg_resp_data,

  output logic [63:0] n_vert,
  output logic [63:0] n_inedges,
  output logic [63:0] vaddr,
  output logic [63:0] ieaddr,
  output logic [63:0] write_addr0,
  output logic [63:0] write_addr1,

  output logic        core_start,
  output logic        core_busy,
  input  logic        core_done,
  input  logic [63:0] core_result
);

  state_e      state_q, state_d;

  logic [63:0] n_vert_q,      n_vert_d;
  logic [63:0] n_inedges_q,   n_inedges_d;
  logic [63:0] vaddr_q,       vaddr_d;
  logic [63:0] ieaddr_q,      ieaddr_d;
  logic [63:0] write_addr0_q, write_addr0_d;
  logic [63:0] write_addr1_q, write_addr1_d;

  logic [63:0] result_q,      result_d;
  logic        pending_q,     pending_d;
  logic        overflow_q,    overflow_d;
  logic        core_start_q,  core_start_d;
  logic        resp_valid_q,  resp_valid_d;
  logic [63:0] resp_data_q,   resp_data_d;

  logic        rd_req;
  logic        wr_req;
  logic        params_open;
  logic        done_in_run;
  logic        busy;
  logic        done;

  assign rd_req      = softreg_req_valid & ~softreg_req_isWrite;
  assign wr_req      = softreg_req_valid &  softreg_req_isWrite;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign params_open = ~busy;
  // core_done is only meaningful while the core is actually running
  assign done_in_run = core_done & busy;

  always_comb begin
    state_d       = state_q;
    n_vert_d      = n_vert_q;
    n_inedges_d   = n_inedges_q;
    vaddr_d       = vaddr_q;
    ieaddr_d      = ieaddr_q;
    write_addr0_d = write_addr0_q;
    write_addr1_d = write_addr1_q;
    result_d      = result_q;
    pending_d     = pending_q;
    overflow_d    = overflow_q;
    core_start_d  = 1'b0;
    resp_valid_d  = 1'b0;
    resp_data_d   = '0;

    // Host reads. While a DONE_ALL read is parked every other read is
    // dropped, which keeps the response port collision-free.
    if (rd_req) begin
      if (pending_q) begin
        overflow_d = 1'b1;
      end else begin
        resp_valid_d = 1'b1;
        case (softreg_req_addr)
          ADDR_N_VERT:      resp_data_d = n_vert_q;
          ADDR_N_INEDGES:   resp_data_d = n_inedges_q;
          ADDR_VADDR:       resp_data_d = vaddr_q;
          ADDR_IEADDR:      resp_data_d = ieaddr_q;
          ADDR_WRITE_ADDR0: resp_data_d = write_addr0_q;
          ADDR_WRITE_ADDR1: resp_data_d = write_addr1_q;
          ADDR_STATUS:      resp_data_d = status_word(busy, done, overflow_q);
          ADDR_DONE_ALL: begin
            if (done) begin
              resp_data_d = result_q;
            end else if (done_in_run) begin
              // Completion arrives in the same cycle: answer directly with
              // the live result instead of parking the read.
              resp_data_d = core_result;
            end else begin
              resp_valid_d = 1'b0;
              pending_d    = 1'b1;
            end
          end
          default:          resp_data_d = '0;
        endcase
      end
    end

    // Host writes; parameters are frozen for the duration of a run.
    if (wr_req && params_open) begin
      case (softreg_req_addr)
        ADDR_N_VERT:      n_vert_d      = softreg_req_data;
        ADDR_N_INEDGES:   n_inedges_d   = softreg_req_data;
        ADDR_VADDR:       vaddr_d       = softreg_req_data;
        ADDR_IEADDR:      ieaddr_d      = softreg_req_data;
        ADDR_WRITE_ADDR0: write_addr0_d = softreg_req_data;
        ADDR_WRITE_ADDR1: write_addr1_d = softreg_req_data;
        ADDR_DONE_READ_PARAMS: begin
          state_d      = ST_RUN;
          core_start_d = 1'b1;
        end
        default: ;
      endcase
    end

    // Completion. A parked read cannot coexist with a new response because
    // any read arriving while pending was dropped above.
    if (done_in_run) begin
      state_d  = ST_DONE;
      result_d = core_result;
      if (pending_q) begin
        pending_d    = 1'b0;
        resp_valid_d = 1'b1;
        resp_data_d  = core_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      n_vert_q      <= '0;
      n_inedges_q   <= '0;
      vaddr_q       <= '0;
      ieaddr_q      <= '0;
      write_addr0_q <= '0;
      write_addr1_q <= '0;
      result_q      <= '0;
      pending_q     <= 1'b0;
      overflow_q    <= 1'b0;
      core_start_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      n_vert_q      <= n_vert_d;
      n_inedges_q   <= n_inedges_d;
      vaddr_q       <= vaddr_d;
      ieaddr_q      <= ieaddr_d;
      write_addr0_q <= write_addr0_d;
      write_addr1_q <= write_addr1_d;
      result_q      <= result_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      core_start_q  <= core_start_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign softreg_resp_valid = resp_valid_q;
  assign softreg_resp_data  = resp_data_q;
  assign n_vert             = n_vert_q;
  assign n_inedges          = n_inedges_q;
  assign vaddr              = vaddr_q;
  assign ieaddr             = ieaddr_q;
  assign write_addr0        = write_addr0_q;
  assign write_addr1        = write_addr1_q;
  assign core_start         = core_start_q;
  assign core_busy          = busy;

endmodule
